ripple_accumulator: RTL and testbench

- Sequential consumer stage for the combinational ripple-carry adder.
- Accepts a stream of WIDTH-bit operands over a valid/ready handshake.
- Sums exactly NUM_SAMPLES accepted beats into a registered accumulator, tracking carry-out overflow.
- Presents the total on a valid/ready output port and holds it until the output handshake completes.

---
 rtl/ripple_accumulator_pkg.sv | 13 +
 rtl/acc_adder.sv | 23 ++
 rtl/ripple_accumulator.sv | 110 +++++++++++
 tb/tb_ripple_accumulator.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/ripple_accumulator_pkg.sv
// Shared definitions for the ripple accumulator: FSM state type and default sizing.
package ripple_accumulator_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    HOLD = 2'd2
  } acc_state_t;

  localparam int unsigned DEFAULT_WIDTH       = 4;
  localparam int unsigned DEFAULT_NUM_SAMPLES = 4;

endpackage

// File: rtl/acc_adder.sv
// Parametric combinational ripple-carry adder built from a chain of full-adder cells.
module acc_adder #(
  parameter int unsigned WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  logic [WIDTH:0] carry;

  assign carry[0] = cin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_fa
    assign sum[i]     = a[i] ^ b[i] ^ carry[i];
    assign carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
  end

  assign cout = carry[WIDTH];

endmodule

// File: rtl/ripple_accumulator.sv
// Sums NUM_SAMPLES handshaked operands into a registered total with sticky carry-out,
// then holds the result on a valid/ready output until it is taken.
module ripple_accumulator
  import ripple_accumulator_pkg::*;
#(
  parameter  int unsigned WIDTH       = DEFAULT_WIDTH,
  parameter  int unsigned NUM_SAMPLES = DEFAULT_NUM_SAMPLES,
  localparam int unsigned CNT_W       = $clog2(NUM_SAMPLES + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_ovf,
  output logic [CNT_W-1:0] count
);

  acc_state_t       state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic             ovf_q, ovf_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [WIDTH-1:0] add_sum;
  logic             add_cout;
  logic [CNT_W-1:0] cnt_inc;
  logic             accept;
  logic             emit;

  acc_adder #(
    .WIDTH (WIDTH)
  ) u_adder (
    .a    (acc_q),
    .b    (in_data),
    .cin  (1'b0),
    .sum  (add_sum),
    .cout (add_cout)
  );

  // Handshake flags decode from state only, never from in_valid/out_ready.
  assign in_ready  = (state_q != HOLD);
  assign out_valid = (state_q == HOLD);
  assign out_sum   = acc_q;
  assign out_ovf   = ovf_q;
  assign count     = cnt_q;

  assign accept  = in_valid && in_ready;
  assign emit    = out_valid && out_ready;
  assign cnt_inc = cnt_q + CNT_W'(1);

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    ovf_d   = ovf_q;
    cnt_d   = cnt_q;
    if (clear) begin
      state_d = IDLE;
      acc_d   = '0;
      ovf_d   = 1'b0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            acc_d   = in_data;
            ovf_d   = 1'b0;
            cnt_d   = CNT_W'(1);
            state_d = (NUM_SAMPLES == 1) ? HOLD : ACC;
          end
        end
        ACC: begin
          if (accept) begin
            acc_d = add_sum;
            ovf_d = ovf_q | add_cout;
            cnt_d = cnt_inc;
            if (cnt_inc == CNT_W'(NUM_SAMPLES)) state_d = HOLD;
          end
        end
        HOLD: begin
          if (emit) begin
            state_d = IDLE;
            acc_d   = '0;
            ovf_d   = 1'b0;
            cnt_d   = '0;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_ripple_accumulator.sv
// Self-checking bench for ripple_accumulator: reference model feeds a result scoreboard.
module tb_ripple_accumulator;

  localparam int unsigned WIDTH = 4;
  localparam int unsigned NS    = 4;
  localparam int unsigned CNT_W = $clog2(NS + 1);
  localparam int unsigned BOUND = 20;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             clear;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic             out_ovf;
  logic [CNT_W-1:0] count;

  int unsigned errors = 0;
  int unsigned checks = 0;

  logic [WIDTH:0]   exp_q[$];
  logic [WIDTH-1:0] m_acc;
  logic             m_ovf;
  int unsigned      m_cnt;

  ripple_accumulator #(
    .WIDTH       (WIDTH),
    .NUM_SAMPLES (NS)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_ovf   (out_ovf),
    .count     (count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model update for one accepted beat; pushes the result after the last beat.
  task automatic model_accept(input logic [WIDTH-1:0] d);
    logic [WIDTH:0] s;
    if (m_cnt == 0) begin
      m_acc = d;
      m_ovf = 1'b0;
    end else begin
      s     = {1'b0, m_acc} + {1'b0, d};
      m_acc = s[WIDTH-1:0];
      m_ovf = m_ovf | s[WIDTH];
    end
    m_cnt++;
    if (m_cnt == NS) begin
      exp_q.push_back({m_ovf, m_acc});
      m_cnt = 0;
    end
  endtask

  // Presents one beat starting at a negedge; returns at the negedge after the accepting posedge.
  task automatic send(input logic [WIDTH-1:0] d);
    int unsigned n;
    in_valid = 1'b1;
    in_data  = d;
    n = 0;
    while (!in_ready && n < BOUND) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check("send_timeout", 32'(in_ready), 32'd1);
    @(negedge clk);
    model_accept(d);
    in_valid = 1'b0;
  endtask

  task automatic collect(input string tag);
    int unsigned    n;
    logic [WIDTH:0] e;
    n = 0;
    while (!out_valid && n < BOUND) begin
      @(negedge clk);
      n++;
    end
    if (!out_valid) begin
      check({tag, "_timeout"}, 32'(out_valid), 32'd1);
    end else begin
      e = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
      check({tag, "_sum"}, 32'(out_sum), 32'(e[WIDTH-1:0]));
      check({tag, "_ovf"}, 32'(out_ovf), 32'(e[WIDTH]));
      check({tag, "_cnt"}, 32'(count), NS);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check({tag, "_post_valid"}, 32'(out_valid), 32'd0);
      check({tag, "_post_ready"}, 32'(in_ready), 32'd1);
      check({tag, "_post_cnt"}, 32'(count), 32'd0);
    end
  endtask

  initial begin
    logic [WIDTH-1:0] beats[4];
    m_acc = '0; m_ovf = 1'b0; m_cnt = 0;
    rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_cnt", 32'(count), 32'd0);
    check("rst_ready", 32'(in_ready), 32'd1);

    // Basic sum with one-cycle latency after the last beat
    send(4'd1); send(4'd2); send(4'd3); send(4'd4);
    check("basic_latency", 32'(out_valid), 32'd1);
    collect("basic");

    send(4'd11); send(4'd11); send(4'd0); send(4'd0);
    collect("ovf");
    send(4'd1); send(4'd1); send(4'd1); send(4'd1);
    collect("ovf_cleared");

    // Backpressure: pending beat of 7 must not be taken while holding
    send(4'd2); send(4'd2); send(4'd2); send(4'd2);
    in_valid = 1'b1; in_data = 4'd7;
    for (int i = 0; i < 5; i++) begin
      check("bp_ready", 32'(in_ready), 32'd0);
      check("bp_sum", 32'(out_sum), 32'd8);
      check("bp_cnt", 32'(count), NS);
      @(negedge clk);
    end
    in_valid = 1'b0;
    collect("bp");
    send(4'd3);
    check("bp_new_first", 32'(count), 32'd1);
    send(4'd3); send(4'd3); send(4'd3);
    collect("bp_next");

    beats = '{4'd3, 4'd0, 4'd5, 4'd1};
    for (int i = 0; i < 4; i++) begin
      send(beats[i]);
      check("bub_cnt", 32'(count), 32'(i + 1));
      if (i < 3) begin
        repeat (2) @(negedge clk);
        check("bub_hold_cnt", 32'(count), 32'(i + 1));
      end
    end
    collect("bubbles");

    // Clear mid-accumulation discards the partial result and the same-cycle beat
    send(4'd5); send(4'd6);
    clear = 1'b1; in_valid = 1'b1; in_data = 4'd9;
    @(negedge clk);
    clear = 1'b0; in_valid = 1'b0;
    m_cnt = 0;
    check("clr_cnt", 32'(count), 32'd0);
    check("clr_ready", 32'(in_ready), 32'd1);
    check("clr_valid", 32'(out_valid), 32'd0);
    send(4'd1); send(4'd1); send(4'd1); send(4'd1);
    collect("clr_after");

    send(4'd1); send(4'd2); send(4'd3); send(4'd4);
    check("clrh_valid_pre", 32'(out_valid), 32'd1);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    void'(exp_q.pop_front());
    check("clrh_valid", 32'(out_valid), 32'd0);
    check("clrh_cnt", 32'(count), 32'd0);

    // Asynchronous reset while holding a result
    send(4'd7); send(4'd7); send(4'd7); send(4'd7);
    check("arst_valid_pre", 32'(out_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_valid", 32'(out_valid), 32'd0);
    check("arst_cnt", 32'(count), 32'd0);
    check("arst_sum", 32'(out_sum), 32'd0);
    void'(exp_q.pop_front());
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("arst_ready", 32'(in_ready), 32'd1);
    send(4'd15); send(4'd1); send(4'd0); send(4'd2);
    collect("arst_after");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
